// File: rtl/sdram_burst_responder.sv
// Burst read engine: issues one 16-bit memory read at a time and returns the words as
// 16-bit beats or packed 32-bit beats, with an end-of-burst pulse on the final beat.
module sdram_burst_responder #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              burst_rd,
  input  logic [ADDR_W-1:0] burst_addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              burst_32bit,
  output logic [31:0]       burst_data,
  output logic              burst_data_valid,
  output logic              burst_data_done,
  output logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_q,
  input  logic              mem_q_valid
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              mode_q, mode_d;
  logic              half_q, half_d;
  logic [15:0]       hi_q, hi_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              last;

  // Word addresses are always even; the low address bit carries no information.
  logic unused_addr_bit;
  assign unused_addr_bit = burst_addr[0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    half_d     = half_q;
    hi_d       = hi_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    last       = (rem_q == LEN_W'(1));

    case (state_q)
      StIdle: begin
        if (burst_rd) begin
          addr_d  = {burst_addr[ADDR_W-1:1], 1'b0};
          rem_d   = burst_len;
          mode_d  = burst_32bit;
          half_d  = 1'b0;
          done_d  = (burst_len == '0);
          state_d = (burst_len == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = addr_q;
        state_d    = StWait;
      end
      StWait: begin
        if (mem_q_valid) begin
          addr_d  = addr_q + ADDR_W'(2);
          rem_d   = rem_q - LEN_W'(1);
          state_d = last ? StDone : StIssue;
          if (!mode_q) begin
            data_d  = {16'h0000, mem_q};
            valid_d = 1'b1;
            done_d  = last;
          end else if (half_q) begin
            data_d  = {hi_q, mem_q};
            valid_d = 1'b1;
            done_d  = last;
            half_d  = 1'b0;
          end else if (last) begin
            // Odd-length packed burst: lone final word goes in the upper half.
            data_d  = {mem_q, 16'h0000};
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            hi_d   = mem_q;
            half_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      mode_q     <= 1'b0;
      half_q     <= 1'b0;
      hi_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      half_q     <= half_d;
      hi_q       <= hi_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign burst_data       = data_q;
  assign burst_data_valid = valid_q;
  assign burst_data_done  = done_q;
  assign busy             = (state_q != StIdle);
  assign mem_rd           = mem_rd_q;
  assign mem_addr         = mem_addr_q;

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Scoreboard bench: stimulus queues expected read addresses and beats, a negedge monitor
// pops and compares them, and a small memory model answers each read two cycles later.
module tb_sdram_burst_responder;

  localparam int unsigned ADDR_W = 26;
  localparam int unsigned LEN_W  = 11;

  logic              CLK;
  logic              nRESET;
  logic              burst_rd;
  logic [ADDR_W-1:0] burst_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              burst_32bit;
  logic [31:0]       burst_data;
  logic              burst_data_valid;
  logic              burst_data_done;
  logic              busy;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_q;
  logic              mem_q_valid;

  typedef struct packed {
    logic [31:0] data;
    logic        valid;
    logic        done;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_addrs[$];
  logic [15:0] words[$];
  logic        resp_en;
  int          vectors;
  int          miscompares;

  sdram_burst_responder #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .CLK             (CLK),
    .nRESET          (nRESET),
    .burst_rd        (burst_rd),
    .burst_addr      (burst_addr),
    .burst_len       (burst_len),
    .burst_32bit     (burst_32bit),
    .burst_data      (burst_data),
    .burst_data_valid(burst_data_valid),
    .burst_data_done (burst_data_done),
    .busy            (busy),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_q           (mem_q),
    .mem_q_valid     (mem_q_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] data, input logic done);
    beat_t b;
    b.data  = data;
    b.valid = 1'b1;
    b.done  = done;
    exp_beats.push_back(b);
  endtask

  task automatic start_burst(input logic [ADDR_W-1:0] a, input int l, input logic m);
    @(posedge CLK);
    #1;
    burst_addr  = a;
    burst_len   = LEN_W'(l);
    burst_32bit = m;
    burst_rd    = 1'b1;
    @(posedge CLK);
    #1;
    burst_rd = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (busy && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check({name, " idle"}, 32'(busy), 32'd0);
  endtask

  // Monitor: every read strobe and every beat/done must match the head of its queue.
  always @(negedge CLK) begin
    if (nRESET) begin
      if (mem_rd) begin
        if (exp_addrs.size() == 0) begin
          check("unexpected mem_rd", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          check("mem_addr", 32'(mem_addr), exp_addrs.pop_front());
        end
      end
      if (burst_data_valid || burst_data_done) begin
        if (exp_beats.size() == 0) begin
          check("unexpected beat", burst_data, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          check("valid", 32'(burst_data_valid), 32'(b.valid));
          check("done", 32'(burst_data_done), 32'(b.done));
          if (b.valid) check("burst_data", burst_data, b.data);
        end
      end
    end
  end

  // Memory model: one word back two cycles after each read strobe.
  initial begin
    mem_q       = '0;
    mem_q_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (resp_en && nRESET && mem_rd) begin
        @(posedge CLK);
        @(posedge CLK);
        #1;
        mem_q       = (words.size() != 0) ? words.pop_front() : 16'hDEAD;
        mem_q_valid = 1'b1;
        @(posedge CLK);
        #1;
        mem_q_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    resp_en     = 1'b1;
    nRESET      = 1'b0;
    burst_rd    = 1'b0;
    burst_addr  = '0;
    burst_len   = '0;
    burst_32bit = 1'b0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(burst_data_valid), 32'd0);
    check("reset data", burst_data, 32'd0);
    check("reset mem_rd", 32'(mem_rd), 32'd0);
    repeat (2) @(posedge CLK);
    #3 nRESET = 1'b1;

    // 32-bit, len 4, with first-read latency check.
    words       = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
    exp_addrs   = '{32'h100, 32'h102, 32'h104, 32'h106};
    push_beat(32'hA1A1_B2B2, 1'b0);
    push_beat(32'hC3C3_D4D4, 1'b1);
    start_burst(26'h100, 4, 1'b1);
    check("busy after accept", 32'(busy), 32'd1);
    check("no mem_rd at +1", 32'(mem_rd), 32'd0);
    @(posedge CLK);
    #1;
    check("mem_rd at +2", 32'(mem_rd), 32'd1);
    wait_idle("t1");
    check("data held", burst_data, 32'hC3C3_D4D4);
    check("valid low after", 32'(burst_data_valid), 32'd0);

    // 16-bit, len 3.
    words = '{16'h1111, 16'h2222, 16'h3333};
    exp_addrs = '{32'h40, 32'h42, 32'h44};
    push_beat(32'h0000_1111, 1'b0);
    push_beat(32'h0000_2222, 1'b0);
    push_beat(32'h0000_3333, 1'b1);
    start_burst(26'h40, 3, 1'b0);
    wait_idle("t2");

    // 32-bit, odd length.
    words = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
    exp_addrs = '{32'h80, 32'h82, 32'h84};
    push_beat(32'h0A0A_0B0B, 1'b0);
    push_beat(32'h0C0C_0000, 1'b1);
    start_burst(26'h81, 3, 1'b1);
    wait_idle("t3");

    // Address wrap at the top of the space.
    words = '{16'h5555, 16'h6666};
    exp_addrs = '{32'h3FF_FFFE, 32'h0};
    push_beat(32'h0000_5555, 1'b0);
    push_beat(32'h0000_6666, 1'b1);
    start_burst(26'h3FF_FFFE, 2, 1'b0);
    wait_idle("t4");

    // Zero length: lone done pulse.
    begin
      beat_t b;
      b.data  = '0;
      b.valid = 1'b0;
      b.done  = 1'b1;
      exp_beats.push_back(b);
    end
    start_burst(26'h200, 0, 1'b1);
    wait_idle("t5");

    // burst_rd while busy is ignored.
    words = '{16'h7777, 16'h8888};
    exp_addrs = '{32'h300, 32'h302};
    push_beat(32'h0000_7777, 1'b0);
    push_beat(32'h0000_8888, 1'b1);
    start_burst(26'h300, 2, 1'b0);
    start_burst(26'h500, 1, 1'b1);
    wait_idle("t6");

    // Reset in WAIT, then a late word that must not produce a beat.
    resp_en = 1'b0;
    exp_addrs = '{32'h200};
    start_burst(26'h200, 2, 1'b0);
    n = 0;
    @(negedge CLK);
    while (!mem_rd && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("t7 mem_rd seen", 32'(mem_rd), 32'd1);
    @(negedge CLK);
    #2 nRESET = 1'b0;
    #1;
    check("t7 busy", 32'(busy), 32'd0);
    check("t7 mem_addr", 32'(mem_addr), 32'd0);
    check("t7 mem_rd", 32'(mem_rd), 32'd0);
    check("t7 valid", 32'(burst_data_valid), 32'd0);
    check("t7 done", 32'(burst_data_done), 32'd0);
    check("t7 data", burst_data, 32'd0);
    @(posedge CLK);
    #3 nRESET = 1'b1;
    @(posedge CLK);
    #1;
    mem_q       = 16'hFFFF;
    mem_q_valid = 1'b1;
    @(posedge CLK);
    #1;
    mem_q_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("t7 busy after", 32'(busy), 32'd0);
    check("t7 data after", burst_data, 32'd0);
    resp_en = 1'b1;

    // Normal burst after the abandoned one.
    words = '{16'h9999};
    exp_addrs = '{32'h10};
    push_beat(32'h0000_9999, 1'b1);
    start_burst(26'h10, 1, 1'b0);
    wait_idle("t8");

    repeat (3) @(posedge CLK);
    check("beats left", 32'(exp_beats.size()), 32'd0);
    check("addrs left", 32'(exp_addrs.size()), 32'd0);
    check("words left", 32'(words.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
